// File: rtl/comm_slave_if.sv
// comm_slave_if: serial RX line, command handshake and status pulses of the
// two-byte command receiver. The master side drives RX and the acknowledge.
interface comm_slave_if;
    logic        RX;
    logic        clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;
    logic        tmo;

    modport master (
        output RX,
        output clr_cmd_rdy,
        input  cmd,
        input  cmd_rdy,
        input  frm_err,
        input  tmo
    );

    modport slave (
        input  RX,
        input  clr_cmd_rdy,
        output cmd,
        output cmd_rdy,
        output frm_err,
        output tmo
    );
endinterface

// File: rtl/comm_slave.sv
// comm_slave: 8N1 UART receiver that pairs consecutive bytes into a 16-bit
// command (high byte first) with a sticky ready flag.
// Optional macro CMD_TIMEOUT_EN: abandons a pending high byte when no start
// edge arrives within TIMEOUT_BITS bit periods; without it tmo is tied low.
module comm_slave #(
    parameter int unsigned BAUD_DIV     = 2604,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    comm_slave_if.slave bus
);

    localparam logic [11:0] HalfLoad = 12'(BAUD_DIV / 2 - 1);
    localparam logic [11:0] BitLoad  = 12'(BAUD_DIV - 1);

    // Reject configurations the 12-bit baud counter cannot represent.
    if (BAUD_DIV < 8 || BAUD_DIV > 4095 || TIMEOUT_BITS < 1) begin : g_bad_cfg
        $error("comm_slave: BAUD_DIV must be 8..4095 and TIMEOUT_BITS >= 1");
    end

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic {PairWaitHi, PairWaitLo} pair_state_e;

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e   rx_state_q;
    logic [11:0] baud_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        byte_vld_q, frm_err_q;
    pair_state_e pair_state_q;
    logic [7:0]  hold_q;
    logic [15:0] cmd_q;
    logic        cmd_rdy_q;
    logic        start_det;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned   TmoW    = (TIMEOUT_BITS > 1) ? $clog2(TIMEOUT_BITS) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_BITS - 1);
    logic            tmo_q;
    logic            tmo_run_q;
    logic [11:0]     tmo_div_q;
    logic [TmoW-1:0] tmo_bits_q;
`endif

    // Falling edge of the synchronized line while the receiver is idle.
    assign start_det = (rx_state_q == RxIdle) && rx_prev_q && !rx_sync_q;

    // Two-flop synchronizer plus edge-detect history, preset high (line idle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Bit receiver: start re-sample at half bit, 8 data bits LSB first, stop check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RxIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    if (start_det) begin
                        rx_state_q <= RxStart;
                        baud_cnt_q <= HalfLoad;
                    end
                end
                RxStart: begin
                    if (baud_cnt_q == '0) begin
                        if (rx_sync_q) begin
                            rx_state_q <= RxIdle;
                        end else begin
                            rx_state_q <= RxData;
                            baud_cnt_q <= BitLoad;
                            bit_cnt_q  <= '0;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 12'd1;
                    end
                end
                RxData: begin
                    if (baud_cnt_q == '0) begin
                        shift_q    <= {rx_sync_q, shift_q[7:1]};
                        baud_cnt_q <= BitLoad;
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_state_q <= RxStop;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 12'd1;
                    end
                end
                RxStop: begin
                    if (baud_cnt_q == '0) begin
                        byte_vld_q <= rx_sync_q;
                        frm_err_q  <= !rx_sync_q;
                        rx_state_q <= RxIdle;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 12'd1;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // Byte pairing: hold the high byte, publish {hi, lo}; a set beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_state_q <= PairWaitHi;
            hold_q       <= '0;
            cmd_q        <= '0;
            cmd_rdy_q    <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            tmo_q        <= 1'b0;
            tmo_run_q    <= 1'b0;
            tmo_div_q    <= '0;
            tmo_bits_q   <= '0;
`endif
        end else begin
`ifdef CMD_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
            if (bus.clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end
            unique case (pair_state_q)
                PairWaitHi: begin
                    if (byte_vld_q) begin
                        hold_q       <= shift_q;
                        cmd_rdy_q    <= 1'b0;
                        pair_state_q <= PairWaitLo;
`ifdef CMD_TIMEOUT_EN
                        tmo_run_q    <= !start_det;
                        tmo_div_q    <= '0;
                        tmo_bits_q   <= '0;
`endif
                    end
                end
                PairWaitLo: begin
                    if (byte_vld_q) begin
                        cmd_q        <= {hold_q, shift_q};
                        cmd_rdy_q    <= 1'b1;
                        pair_state_q <= PairWaitHi;
`ifdef CMD_TIMEOUT_EN
                        tmo_run_q    <= 1'b0;
                    end else if (start_det) begin
                        tmo_run_q  <= 1'b0;
                        tmo_div_q  <= '0;
                        tmo_bits_q <= '0;
                    end else if (tmo_run_q) begin
                        if (tmo_div_q == BitLoad) begin
                            tmo_div_q <= '0;
                            if (tmo_bits_q == TmoLast) begin
                                tmo_q        <= 1'b1;
                                tmo_run_q    <= 1'b0;
                                hold_q       <= '0;
                                pair_state_q <= PairWaitHi;
                            end else begin
                                tmo_bits_q <= tmo_bits_q + 1'b1;
                            end
                        end else begin
                            tmo_div_q <= tmo_div_q + 12'd1;
                        end
`endif
                    end
                end
                default: pair_state_q <= PairWaitHi;
            endcase
        end
    end

    assign bus.cmd     = cmd_q;
    assign bus.cmd_rdy = cmd_rdy_q;
    assign bus.frm_err = frm_err_q;
`ifdef CMD_TIMEOUT_EN
    assign bus.tmo     = tmo_q;
`else
    assign bus.tmo     = 1'b0;
`endif

endmodule

// File: tb/tb_comm_slave.sv
// tb_comm_slave: drives UART frames into comm_slave and checks the command
// outputs against a byte-level pairing model.
`timescale 1ns/1ps
module tb_comm_slave;

    localparam int unsigned BAUD  = 16;
    localparam int unsigned TBITS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    comm_slave_if bus_if();

    comm_slave #(
        .BAUD_DIV     (BAUD),
        .TIMEOUT_BITS (TBITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse monitors, sampled mid-cycle.
    int frm_cnt     = 0;
    int tmo_cnt     = 0;
    int rdy_clr_cnt = 0;
    always @(negedge clk) begin
        if (bus_if.frm_err === 1'b1) frm_cnt <= frm_cnt + 1;
        if (bus_if.tmo === 1'b1) tmo_cnt <= tmo_cnt + 1;
        if (bus_if.cmd_rdy === 1'b1 && bus_if.clr_cmd_rdy === 1'b1) rdy_clr_cnt <= rdy_clr_cnt + 1;
    end

    // Byte-level reference model of the pairing rules.
    logic        m_have_hi = 1'b0;
    logic [7:0]  m_hi      = 8'h00;
    logic [15:0] m_cmd     = 16'h0000;
    logic        m_rdy     = 1'b0;
    int          m_frm     = 0;

    task automatic model_byte(input logic [7:0] b, input logic good);
        if (!good) begin
            m_frm++;
        end else if (!m_have_hi) begin
            m_hi      = b;
            m_have_hi = 1'b1;
            m_rdy     = 1'b0;
        end else begin
            m_cmd     = {m_hi, b};
            m_rdy     = 1'b1;
            m_have_hi = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_have_hi = 1'b0;
        m_hi      = 8'h00;
        m_cmd     = 16'h0000;
        m_rdy     = 1'b0;
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic send_bit(input logic v);
        bus_if.RX = v;
        repeat (BAUD) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        if (!stop) send_bit(1'b1);
        model_byte(b, stop);
    endtask

    task automatic pulse_clr();
        bus_if.clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus_if.clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        checks++; if (bus_if.cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h want 0000", bus_if.cmd); end
        checks++; if (bus_if.cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", bus_if.cmd_rdy); end
        checks++; if (bus_if.frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm: got %b want 0", bus_if.frm_err); end
        checks++; if (bus_if.tmo !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b want 0", bus_if.tmo); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        checks++; if (bus_if.cmd !== 16'h0000) begin errors++; $display("FAIL idle_cmd: got %h want 0000", bus_if.cmd); end
        checks++; if (bus_if.cmd_rdy !== 1'b0) begin errors++; $display("FAIL idle_rdy: got %b want 0", bus_if.cmd_rdy); end
        checks++; if (frm_cnt !== 0) begin errors++; $display("FAIL idle_frm_pulses: got %0d want 0", frm_cnt); end
        checks++; if (tmo_cnt !== 0) begin errors++; $display("FAIL idle_tmo_pulses: got %0d want 0", tmo_cnt); end
    endtask

    task automatic test_pair();
        int rise_at = -1;
        send_byte(8'hA5, 1'b1);
        // Second byte by hand so the ready edge can be located inside the stop bit.
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(logic'((8'h3C >> i) & 8'h01));
        bus_if.RX = 1'b1;
        for (int j = 1; j <= int'(BAUD); j++) begin
            @(posedge clk);
            #1;
            if (rise_at < 0 && bus_if.cmd_rdy === 1'b1) rise_at = j;
        end
        model_byte(8'h3C, 1'b1);
        checks++;
        if (rise_at < int'(BAUD / 2) || rise_at > int'(BAUD / 2) + 5) begin
            errors++; $display("FAIL pair_rdy_latency: rose at stop cycle %0d want %0d..%0d", rise_at, BAUD / 2, BAUD / 2 + 5);
        end
        checks++; if (bus_if.cmd !== 16'hA53C) begin errors++; $display("FAIL pair_cmd: got %h want a53c", bus_if.cmd); end
        checks++; if (bus_if.cmd_rdy !== 1'b1) begin errors++; $display("FAIL pair_rdy: got %b want 1", bus_if.cmd_rdy); end
        pulse_clr();
        checks++; if (bus_if.cmd_rdy !== 1'b0) begin errors++; $display("FAIL clr_rdy: got %b want 0", bus_if.cmd_rdy); end
        checks++; if (bus_if.cmd !== 16'hA53C) begin errors++; $display("FAIL clr_cmd_hold: got %h want a53c", bus_if.cmd); end
    endtask

    task automatic test_frame_err();
        int f0 = frm_cnt;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b1);
        checks++; if (frm_cnt - f0 !== 1) begin errors++; $display("FAIL frm_pulses: got %0d want 1", frm_cnt - f0); end
        checks++; if (bus_if.cmd !== 16'h1256) begin errors++; $display("FAIL frm_cmd: got %h want 1256", bus_if.cmd); end
        checks++; if (bus_if.cmd_rdy !== 1'b1) begin errors++; $display("FAIL frm_rdy: got %b want 1", bus_if.cmd_rdy); end
    endtask

    task automatic test_set_wins();
        int r0;
        bus_if.clr_cmd_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        r0 = rdy_clr_cnt;
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        m_rdy = 1'b0;
        checks++; if (rdy_clr_cnt - r0 !== 1) begin errors++; $display("FAIL setwins_rdy_cycles: got %0d want 1", rdy_clr_cnt - r0); end
        checks++; if (bus_if.cmd_rdy !== 1'b0) begin errors++; $display("FAIL setwins_rdy_after: got %b want 0", bus_if.cmd_rdy); end
        checks++; if (bus_if.cmd !== 16'hBEEF) begin errors++; $display("FAIL setwins_cmd: got %h want beef", bus_if.cmd); end
        bus_if.clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_glitch();
        int f0 = frm_cnt;
        bus_if.RX = 1'b0;
        repeat (8) @(posedge clk);
        #1 bus_if.RX = 1'b1;
        repeat (3 * BAUD) @(posedge clk);
        #1;
        checks++; if (frm_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_frm: got %0d want 0", frm_cnt - f0); end
        checks++; if (bus_if.cmd !== m_cmd || bus_if.cmd_rdy !== m_rdy) begin
            errors++; $display("FAIL glitch_outputs: got %h/%b want %h/%b", bus_if.cmd, bus_if.cmd_rdy, m_cmd, m_rdy);
        end
        send_byte(8'hC3, 1'b1);
        send_byte(8'h5A, 1'b1);
        checks++; if (bus_if.cmd !== 16'hC35A) begin errors++; $display("FAIL glitch_pair_cmd: got %h want c35a", bus_if.cmd); end
        checks++; if (bus_if.cmd_rdy !== 1'b1) begin errors++; $display("FAIL glitch_pair_rdy: got %b want 1", bus_if.cmd_rdy); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h11, 1'b1);
        send_bit(1'b0);
        bus_if.RX = 1'b1;
        repeat (BAUD / 2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (bus_if.cmd !== 16'h0000) begin errors++; $display("FAIL midrst_cmd: got %h want 0000", bus_if.cmd); end
        checks++; if (bus_if.cmd_rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy: got %b want 0", bus_if.cmd_rdy); end
        checks++; if (bus_if.frm_err !== 1'b0 || bus_if.tmo !== 1'b0) begin
            errors++; $display("FAIL midrst_pulses: got %b/%b want 0/0", bus_if.frm_err, bus_if.tmo);
        end
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * BAUD) @(posedge clk);
        #1;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        checks++; if (bus_if.cmd !== 16'h0102) begin errors++; $display("FAIL midrst_pair_cmd: got %h want 0102", bus_if.cmd); end
        checks++; if (bus_if.cmd_rdy !== 1'b1) begin errors++; $display("FAIL midrst_pair_rdy: got %b want 1", bus_if.cmd_rdy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [7:0] b;
            logic       good;
            b    = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send_byte(b, good);
            if ($urandom_range(0, 3) == 0) pulse_clr();
            if ($urandom_range(0, 1) == 0) send_bit(1'b1);
            checks++; if (bus_if.cmd !== m_cmd || bus_if.cmd_rdy !== m_rdy) begin
                errors++; $display("FAIL rand_%0d byte %h good %b: got %h/%b want %h/%b", n, b, good, bus_if.cmd, bus_if.cmd_rdy, m_cmd, m_rdy);
            end
        end
        checks++; if (frm_cnt !== m_frm) begin errors++; $display("FAIL rand_frm_total: got %0d want %0d", frm_cnt, m_frm); end
    endtask

    task automatic test_timeout();
        int t0 = tmo_cnt;
`ifdef CMD_TIMEOUT_EN
        localparam logic [15:0] ExpCmd = 16'h8899;
        localparam logic        ExpRdy = 1'b1;
        localparam int          ExpTmo = 1;
`else
        localparam logic [15:0] ExpCmd = 16'h7788;
        localparam logic        ExpRdy = 1'b0;
        localparam int          ExpTmo = 0;
`endif
        send_byte(8'h77, 1'b1);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        send_byte(8'h88, 1'b1);
        send_byte(8'h99, 1'b1);
        checks++; if (tmo_cnt - t0 !== ExpTmo) begin errors++; $display("FAIL tmo_pulses: got %0d want %0d", tmo_cnt - t0, ExpTmo); end
        checks++; if (bus_if.cmd !== ExpCmd) begin errors++; $display("FAIL tmo_cmd: got %h want %h", bus_if.cmd, ExpCmd); end
        checks++; if (bus_if.cmd_rdy !== ExpRdy) begin errors++; $display("FAIL tmo_rdy: got %b want %b", bus_if.cmd_rdy, ExpRdy); end
    endtask

    initial begin
        bus_if.RX          = 1'b1;
        bus_if.clr_cmd_rdy = 1'b0;
        test_reset();
        test_pair();
        test_frame_err();
        test_set_wins();
        test_glitch();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
